mem_reg_read_stage: RTL and testbench
=====================================

Name: mem_reg_read_stage

Overview:
- Consumer end of the memory issue-queue → register-read link.
- Accepts one mem_dispatch_pack_t per cycle from the memory issue queue.
- Reads two physical-register operands, resolves them against execute/writeback bypass buses, and holds the result in a 2-entry skid buffer that feeds the LSU address-generation stage.
- Drops entries whose source operand came from a load wake-up that has since been cancelled, and reports each such drop to the issue queue for replay.

Parameters:
- XLEN, 32, operand data width.
- PRF_ADDR_W, 6, physical register index width.
- ROB_TAG_W, 5, ROB tag width carried in the dispatch pack.
- NUM_BYP, 2, number of bypass ports; index 0 has the highest priority.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- iq_instr_valid  in  1  issue queue presents an instruction.
- iq_instr_pack  in  mem_dispatch_pack_t  instruction fields: pc, rs1/rs2 preg, rs2_used, imm, rob_tag, mem op.
- rr_ready  out  1  stage can accept an instruction this cycle.
- prf_raddr1 / prf_raddr2  out  PRF_ADDR_W  register-file read addresses; the PRF read is combinational.
- prf_rdata1 / prf_rdata2  in  XLEN  register-file read data.
- byp_valid  in  NUM_BYP  bypass valid bits.
- byp_preg  in  NUM_BYP*PRF_ADDR_W  bypass destination register index per port.
- byp_data  in  NUM_BYP*XLEN  bypass data per port.
- ld_spec_cancel  in  1  the speculative load broadcast (BCAST_ld_spec) is cancelled.
- ld_spec_preg  in  PRF_ADDR_W  destination register of the cancelled load.
- flush  in  1  pipeline flush.
- exe_ready  in  1  LSU accepts an instruction.
- exe_valid  out  1  output entry valid.
- exe_pack  out  mem_rr_pack_t  dispatch fields plus rs1_data and rs2_data.
- replay_valid  out  1  an entry was dropped by a load cancel.
- replay_rob_tag  out  ROB_TAG_W  ROB tag of the dropped entry.

Behaviour:
- Buffer: head (drives exe_*) and skid. States:
  - EMPTY: no valid entry.
  - ONE: head valid.
  - TWO: head and skid valid.
- Ready: rr_ready = !skid_valid, registered. The stage accepts only if iq_instr_valid && rr_ready.
- Accept: prf_raddr1/2 = iq_instr_pack.rs1/rs2, combinational. Operand selection per source:
  - Preg 0 reads 0.
  - Otherwise the first matching byp port in index order.
  - Otherwise prf_rdata.
  - If rs2_used = 0, rs2_data = 0.
- Latency: accept in cycle N → exe_valid in N+1 if the buffer was EMPTY, or if it was ONE and the head is consumed in N.
- Transitions (acc = accept, deq = exe_valid && exe_ready):
  - EMPTY: acc → ONE.
  - ONE:
    - acc && !deq → TWO, new entry goes to skid.
    - acc && deq → ONE, new entry goes to head.
    - !acc && deq → EMPTY.
  - TWO: deq → ONE, skid moves to head. No accept is possible in TWO.
- Order: entries leave in acceptance order. The skid never bypasses the head.
- Cancel: when ld_spec_cancel fires, any held entry with rs1 == ld_spec_preg, or with (rs2_used && rs2 == ld_spec_preg), is invalidated at the clock edge.
  - An instruction accepted in the same cycle is checked too, and is never written.
  - A cancelled head is not presented as deq that cycle. exe_valid is still combinationally masked by the cancel match.
  - If the head is dropped and the skid is valid, the skid compacts into the head.
  - replay_valid pulses for 1 cycle per drop. If two entries drop in the same cycle, the head is reported first and the skid the next cycle, using a 1-deep pending register.
  - Preg 0 never matches.
- Flush: clears all entries, the replay pending register and replay_valid next cycle. rr_ready = 1 next cycle. Flush has priority over accept and cancel.
- Reset: exe_valid = 0, replay_valid = 0, rr_ready = 1, state EMPTY. Pack contents are don't-care. Reset mid-operation behaves exactly like reset.

Optional Feature:
- MEM_RR_PERF_CNT_EN: adds 32-bit saturating counters stall_cycles (exe_valid && !exe_ready), full_cycles (state TWO) and replay_cnt.
  - Counters are cleared by rst only, not by flush.
  - Exposed as output perf_cnt of 96 bits.
- Without the macro: no counters and no port.

Decomposition:
- In Falco_pkg: mem_rr_pack_t (mem_dispatch_pack_t + rs1_data + rs2_data) and the state enum mem_rr_state_e.
- One sub-module: mem_rr_opnd_sel, the combinational zero/bypass/PRF priority mux, instantiated once per source operand.

Test Plan:
- Single op, no bypass: rs1=5 with PRF value 0x1000, exe_ready=1 → exe_valid next cycle, rs1_data=0x1000.
- Bypass priority: byp0 and byp1 both target preg 5 (data 0xA, 0xB) → rs1_data=0xA. Source preg 0 with a bypass on 0 → data 0.
- Backpressure: exe_ready=0, three issues in a row → state TWO and rr_ready=0 after the second. The third is held by the IQ. With exe_ready=1, order is preserved.
- Cancel: TWO with skid rs2=7 (rs2_used), ld_spec_cancel preg 7 → skid dropped, replay_valid=1 with the skid's rob_tag, head unaffected. Cancel matching both entries → two consecutive replay pulses, head first.
- Flush with accept: TWO + flush + iq_instr_valid → EMPTY, exe_valid=0, replay_valid=0, rr_ready=1 next cycle.
- Reset mid-TWO: rst=1 → all outputs at reset values next cycle.

Source files
------------

// File: rtl/falco_pkg.sv
// Shared types for the memory register-read stage: dispatch/output packs,
// buffer state encoding and the load-cancel match helper.
package falco_pkg;

  localparam int XLEN       = 32;
  localparam int PRF_ADDR_W = 6;
  localparam int ROB_TAG_W  = 5;
  localparam int NUM_BYP    = 2;

  typedef enum logic [2:0] {
    MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [PRF_ADDR_W-1:0] rs1;
    logic [PRF_ADDR_W-1:0] rs2;
    logic                  rs2_used;
    logic [XLEN-1:0]       imm;
    logic [ROB_TAG_W-1:0]  rob_tag;
    mem_op_e               mem_op;
  } mem_dispatch_pack_t;

  typedef struct packed {
    mem_dispatch_pack_t disp;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
  } mem_rr_pack_t;

  typedef enum logic [1:0] {
    RR_EMPTY = 2'd0,
    RR_ONE   = 2'd1,
    RR_TWO   = 2'd2
  } mem_rr_state_e;

  // Physical register 0 is hardwired, so it can never be a cancelled load target.
  function automatic logic cancel_hit(mem_dispatch_pack_t p, logic [PRF_ADDR_W-1:0] preg);
    return (preg != '0) && ((p.rs1 == preg) || (p.rs2_used && (p.rs2 == preg)));
  endfunction

endpackage

// File: rtl/mem_rr_opnd_sel.sv
// Operand source mux: preg 0 reads zero, else the lowest-index matching bypass
// port, else the register-file read data.
module mem_rr_opnd_sel import falco_pkg::*; (
  input  logic [PRF_ADDR_W-1:0]         preg,
  input  logic [XLEN-1:0]               prf_data,
  input  logic [NUM_BYP-1:0]            byp_valid,
  input  logic [NUM_BYP*PRF_ADDR_W-1:0] byp_preg,
  input  logic [NUM_BYP*XLEN-1:0]       byp_data,
  output logic [XLEN-1:0]               data
);

  always_comb begin
    data = prf_data;
    // Walk from the highest index down so port 0 is applied last and wins.
    for (int i = NUM_BYP - 1; i >= 0; i--) begin
      if (byp_valid[i] && (byp_preg[i*PRF_ADDR_W +: PRF_ADDR_W] == preg))
        data = byp_data[i*XLEN +: XLEN];
    end
    if (preg == '0) data = '0;
  end

endmodule

// File: rtl/mem_reg_read_stage.sv
// Memory register-read stage: operand read/bypass into a 2-entry skid buffer,
// load-cancel drop with replay report. MEM_RR_PERF_CNT_EN adds perf_cnt.
module mem_reg_read_stage import falco_pkg::*; (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          iq_instr_valid,
  input  mem_dispatch_pack_t            iq_instr_pack,
  output logic                          rr_ready,
  output logic [PRF_ADDR_W-1:0]         prf_raddr1,
  output logic [PRF_ADDR_W-1:0]         prf_raddr2,
  input  logic [XLEN-1:0]               prf_rdata1,
  input  logic [XLEN-1:0]               prf_rdata2,
  input  logic [NUM_BYP-1:0]            byp_valid,
  input  logic [NUM_BYP*PRF_ADDR_W-1:0] byp_preg,
  input  logic [NUM_BYP*XLEN-1:0]       byp_data,
  input  logic                          ld_spec_cancel,
  input  logic [PRF_ADDR_W-1:0]         ld_spec_preg,
  input  logic                          flush,
  input  logic                          exe_ready,
  output logic                          exe_valid,
  output mem_rr_pack_t                  exe_pack,
  output logic                          replay_valid,
  output logic [ROB_TAG_W-1:0]          replay_rob_tag,
  output mem_rr_state_e                 rr_state
`ifdef MEM_RR_PERF_CNT_EN
  ,
  output logic [95:0]                   perf_cnt
`endif
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high
  // at the rising edge; valid never depends on ready of the same interface.
  mem_rr_state_e state_q, state_d;
  mem_rr_pack_t  head_q, head_d, skid_q, skid_d, in_pack;
  logic [XLEN-1:0] rs1_sel, rs2_sel;
  logic head_valid, skid_valid, head_hit, skid_hit, in_hit;
  logic acc, deq, h_keep, s_keep, i_keep;
  logic replay_q, pend_q, first_v, second_v;
  logic [ROB_TAG_W-1:0] replay_tag_q, pend_tag_q, first_tag, second_tag;
  logic [3:0] drop_v;
  logic [ROB_TAG_W-1:0] drop_tag [4];

  mem_rr_opnd_sel u_sel_rs1 (
    .preg(iq_instr_pack.rs1), .prf_data(prf_rdata1), .byp_valid(byp_valid),
    .byp_preg(byp_preg), .byp_data(byp_data), .data(rs1_sel)
  );
  mem_rr_opnd_sel u_sel_rs2 (
    .preg(iq_instr_pack.rs2), .prf_data(prf_rdata2), .byp_valid(byp_valid),
    .byp_preg(byp_preg), .byp_data(byp_data), .data(rs2_sel)
  );

  assign in_pack.disp     = iq_instr_pack;
  assign in_pack.rs1_data = rs1_sel;
  assign in_pack.rs2_data = iq_instr_pack.rs2_used ? rs2_sel : '0;

  assign head_valid = (state_q != RR_EMPTY);
  assign skid_valid = (state_q == RR_TWO);
  assign head_hit   = ld_spec_cancel && head_valid && cancel_hit(head_q.disp, ld_spec_preg);
  assign skid_hit   = ld_spec_cancel && skid_valid && cancel_hit(skid_q.disp, ld_spec_preg);
  assign in_hit     = ld_spec_cancel && cancel_hit(iq_instr_pack, ld_spec_preg);
  assign acc        = iq_instr_valid && rr_ready;
  assign deq        = exe_valid && exe_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RR_EMPTY;
    else     state_q <= state_d;
  end

  // Survivors are compacted in age order: head, then skid, then the new entry.
  always_comb begin
    h_keep  = head_valid && !head_hit && !deq;
    s_keep  = skid_valid && !skid_hit;
    i_keep  = acc && !in_hit;
    head_d  = head_q;
    skid_d  = skid_q;
    state_d = RR_EMPTY;
    if (h_keep) begin
      if (s_keep) begin
        state_d = RR_TWO;
      end else if (i_keep) begin
        skid_d  = in_pack;
        state_d = RR_TWO;
      end else begin
        state_d = RR_ONE;
      end
    end else if (s_keep) begin
      head_d = skid_q;
      if (i_keep) begin
        skid_d  = in_pack;
        state_d = RR_TWO;
      end else begin
        state_d = RR_ONE;
      end
    end else if (i_keep) begin
      head_d  = in_pack;
      state_d = RR_ONE;
    end
    if (flush) state_d = RR_EMPTY;
  end

  always_comb begin
    rr_ready   = (state_q != RR_TWO);
    exe_valid  = head_valid && !head_hit;
    exe_pack   = head_q;
    rr_state   = state_q;
    prf_raddr1 = iq_instr_pack.rs1;
    prf_raddr2 = iq_instr_pack.rs2;
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

  // Pending report is oldest; a third simultaneous drop behind a full pending slot is not reported.
  assign drop_v      = {acc && in_hit, skid_hit, head_hit, pend_q};
  assign drop_tag[0] = pend_tag_q;
  assign drop_tag[1] = head_q.disp.rob_tag;
  assign drop_tag[2] = skid_q.disp.rob_tag;
  assign drop_tag[3] = iq_instr_pack.rob_tag;

  always_comb begin
    first_v    = 1'b0;
    first_tag  = '0;
    second_v   = 1'b0;
    second_tag = '0;
    for (int i = 0; i < 4; i++) begin
      if (drop_v[i]) begin
        if (!first_v) begin
          first_v   = 1'b1;
          first_tag = drop_tag[i];
        end else if (!second_v) begin
          second_v   = 1'b1;
          second_tag = drop_tag[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      replay_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      replay_q <= first_v;
      pend_q   <= second_v;
    end
    replay_tag_q <= first_tag;
    pend_tag_q   <= second_tag;
  end

  assign replay_valid   = replay_q;
  assign replay_rob_tag = replay_tag_q;

`ifdef MEM_RR_PERF_CNT_EN
  logic [31:0] stall_cycles, full_cycles, replay_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      full_cycles  <= '0;
      replay_cnt   <= '0;
    end else begin
      if (exe_valid && !exe_ready && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if ((state_q == RR_TWO) && (full_cycles != '1))       full_cycles  <= full_cycles + 32'd1;
      if (replay_q && (replay_cnt != '1))                   replay_cnt   <= replay_cnt + 32'd1;
    end
  end

  assign perf_cnt = {replay_cnt, full_cycles, stall_cycles};
`endif

endmodule

// File: tb/tb_mem_reg_read_stage.sv
// Directed bench for mem_reg_read_stage: operand select, skid ordering,
// load-cancel replay, flush and reset.
module tb_mem_reg_read_stage;
  import falco_pkg::*;

  logic clk, rst, iq_instr_valid, rr_ready, ld_spec_cancel, flush, exe_ready;
  logic exe_valid, replay_valid;
  mem_dispatch_pack_t iq_instr_pack;
  logic [PRF_ADDR_W-1:0] prf_raddr1, prf_raddr2, ld_spec_preg;
  logic [XLEN-1:0] prf_rdata1, prf_rdata2;
  logic [NUM_BYP-1:0] byp_valid;
  logic [NUM_BYP*PRF_ADDR_W-1:0] byp_preg;
  logic [NUM_BYP*XLEN-1:0] byp_data;
  mem_rr_pack_t exe_pack;
  logic [ROB_TAG_W-1:0] replay_rob_tag;
  mem_rr_state_e rr_state;
  logic [XLEN-1:0] prf [64];
  int errors = 0;
  int checks = 0;

  mem_reg_read_stage dut (
    .clk(clk), .rst(rst), .iq_instr_valid(iq_instr_valid), .iq_instr_pack(iq_instr_pack),
    .rr_ready(rr_ready), .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
    .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2), .byp_valid(byp_valid),
    .byp_preg(byp_preg), .byp_data(byp_data), .ld_spec_cancel(ld_spec_cancel),
    .ld_spec_preg(ld_spec_preg), .flush(flush), .exe_ready(exe_ready),
    .exe_valid(exe_valid), .exe_pack(exe_pack), .replay_valid(replay_valid),
    .replay_rob_tag(replay_rob_tag), .rr_state(rr_state)
  );

  assign prf_rdata1 = prf[prf_raddr1];
  assign prf_rdata2 = prf[prf_raddr2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic mem_dispatch_pack_t mk(logic [5:0] rs1, logic [5:0] rs2, logic used, logic [4:0] tag);
    mem_dispatch_pack_t p;
    p = '0;
    p.pc = 32'h8000_0000 | {27'h0, tag};
    p.rs1 = rs1;
    p.rs2 = rs2;
    p.rs2_used = used;
    p.imm = 32'h10;
    p.rob_tag = tag;
    p.mem_op = MEM_LW;
    return p;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    iq_instr_valid = 1'b0;
    ld_spec_cancel = 1'b0;
    ld_spec_preg = '0;
    flush = 1'b0;
    byp_valid = '0;
  endtask

  task automatic issue(logic [5:0] rs1, logic [5:0] rs2, logic used, logic [4:0] tag);
    iq_instr_valid = 1'b1;
    iq_instr_pack = mk(rs1, rs2, used, tag);
  endtask

  task automatic test_reset;
    rst = 1'b1; idle(); exe_ready = 1'b0; iq_instr_pack = '0;
    byp_preg = '0; byp_data = '0;
    step(); step();
    checks++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL reset_exe_valid: got %b want 0", exe_valid); end
    checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL reset_replay: got %b want 0", replay_valid); end
    checks++; if (rr_ready !== 1'b1) begin errors++; $display("FAIL reset_rr_ready: got %b want 1", rr_ready); end
    checks++; if (rr_state !== RR_EMPTY) begin errors++; $display("FAIL reset_state: got %0d want 0", rr_state); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    exe_ready = 1'b1;
    issue(6'd5, 6'd6, 1'b0, 5'd1);
    #1;
    checks++; if (prf_raddr1 !== 6'd5) begin errors++; $display("FAIL single_raddr1: got %0d want 5", prf_raddr1); end
    checks++; if (prf_raddr2 !== 6'd6) begin errors++; $display("FAIL single_raddr2: got %0d want 6", prf_raddr2); end
    step(); idle();
    checks++; if (exe_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", exe_valid); end
    checks++; if (exe_pack.rs1_data !== 32'h1000) begin errors++; $display("FAIL single_rs1: got %h want 1000", exe_pack.rs1_data); end
    checks++; if (exe_pack.rs2_data !== 32'h0) begin errors++; $display("FAIL single_rs2_unused: got %h want 0", exe_pack.rs2_data); end
    checks++; if (exe_pack.disp.rob_tag !== 5'd1) begin errors++; $display("FAIL single_tag: got %0d want 1", exe_pack.disp.rob_tag); end
    step();
    checks++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", exe_valid); end
  endtask

  task automatic test_bypass;
    exe_ready = 1'b1;
    byp_valid = 2'b11; byp_preg = {6'd5, 6'd5}; byp_data = {32'hB, 32'hA};
    issue(6'd5, 6'd9, 1'b1, 5'd2);
    step();
    byp_preg = {6'd7, 6'd0}; byp_data = {32'hB, 32'hC};
    issue(6'd0, 6'd7, 1'b1, 5'd3);
    checks++; if (exe_pack.rs1_data !== 32'hA) begin errors++; $display("FAIL byp_prio: got %h want a", exe_pack.rs1_data); end
    checks++; if (exe_pack.rs2_data !== 32'h9999) begin errors++; $display("FAIL byp_prf_fallback: got %h want 9999", exe_pack.rs2_data); end
    step(); idle();
    checks++; if (exe_pack.disp.rob_tag !== 5'd3 || exe_valid !== 1'b1) begin errors++; $display("FAIL byp_b2b_tag: got %0d/%b want 3/1", exe_pack.disp.rob_tag, exe_valid); end
    checks++; if (exe_pack.rs1_data !== 32'h0) begin errors++; $display("FAIL byp_preg0: got %h want 0", exe_pack.rs1_data); end
    checks++; if (exe_pack.rs2_data !== 32'hB) begin errors++; $display("FAIL byp_port1: got %h want b", exe_pack.rs2_data); end
    step();
  endtask

  task automatic test_back_to_back;
    exe_ready = 1'b0;
    issue(6'd1, 6'd0, 1'b0, 5'd1); step();
    issue(6'd2, 6'd0, 1'b0, 5'd2);
    checks++; if (rr_ready !== 1'b1 || exe_valid !== 1'b1) begin errors++; $display("FAIL bp_one: ready/valid got %b/%b want 1/1", rr_ready, exe_valid); end
    step();
    issue(6'd3, 6'd0, 1'b0, 5'd3);
    checks++; if (rr_state !== RR_TWO) begin errors++; $display("FAIL bp_two_state: got %0d want 2", rr_state); end
    checks++; if (rr_ready !== 1'b0) begin errors++; $display("FAIL bp_two_ready: got %b want 0", rr_ready); end
    step();
    checks++; if (rr_state !== RR_TWO || exe_pack.disp.rob_tag !== 5'd1) begin errors++; $display("FAIL bp_hold: state/tag got %0d/%0d want 2/1", rr_state, exe_pack.disp.rob_tag); end
    exe_ready = 1'b1;
    step();
    checks++; if (exe_pack.disp.rob_tag !== 5'd2 || rr_state !== RR_ONE) begin errors++; $display("FAIL bp_order2: tag/state got %0d/%0d want 2/1", exe_pack.disp.rob_tag, rr_state); end
    step(); idle();
    checks++; if (exe_pack.disp.rob_tag !== 5'd3 || exe_valid !== 1'b1) begin errors++; $display("FAIL bp_order3: tag/valid got %0d/%b want 3/1", exe_pack.disp.rob_tag, exe_valid); end
    step();
    checks++; if (rr_state !== RR_EMPTY) begin errors++; $display("FAIL bp_empty: got %0d want 0", rr_state); end
  endtask

  task automatic test_cancel;
    exe_ready = 1'b0;
    issue(6'd1, 6'd2, 1'b1, 5'd4); step();
    issue(6'd3, 6'd7, 1'b1, 5'd5); step();
    idle(); ld_spec_cancel = 1'b1; ld_spec_preg = 6'd7;
    #1;
    checks++; if (exe_valid !== 1'b1) begin errors++; $display("FAIL cancel_head_unmasked: got %b want 1", exe_valid); end
    step(); idle();
    checks++; if (replay_valid !== 1'b1 || replay_rob_tag !== 5'd5) begin errors++; $display("FAIL cancel_skid_replay: got %b/%0d want 1/5", replay_valid, replay_rob_tag); end
    checks++; if (rr_state !== RR_ONE || exe_pack.disp.rob_tag !== 5'd4) begin errors++; $display("FAIL cancel_head_kept: got %0d/%0d want 1/4", rr_state, exe_pack.disp.rob_tag); end
    step();
    checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL cancel_pulse: got %b want 0", replay_valid); end
    issue(6'd2, 6'd8, 1'b1, 5'd6); step();
    idle(); ld_spec_cancel = 1'b1; ld_spec_preg = 6'd2;
    #1;
    checks++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL cancel_head_masked: got %b want 0", exe_valid); end
    step(); idle();
    checks++; if (replay_valid !== 1'b1 || replay_rob_tag !== 5'd4) begin errors++; $display("FAIL cancel_both_first: got %b/%0d want 1/4", replay_valid, replay_rob_tag); end
    checks++; if (rr_state !== RR_EMPTY) begin errors++; $display("FAIL cancel_both_state: got %0d want 0", rr_state); end
    step();
    checks++; if (replay_valid !== 1'b1 || replay_rob_tag !== 5'd6) begin errors++; $display("FAIL cancel_both_second: got %b/%0d want 1/6", replay_valid, replay_rob_tag); end
    step();
    checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL cancel_both_end: got %b want 0", replay_valid); end
  endtask

  task automatic test_cancel_edges;
    exe_ready = 1'b0;
    issue(6'd0, 6'd9, 1'b0, 5'd7); step();
    idle(); ld_spec_cancel = 1'b1; ld_spec_preg = 6'd9; step();
    ld_spec_preg = 6'd0; step(); idle();
    checks++; if (replay_valid !== 1'b0 || exe_valid !== 1'b1) begin errors++; $display("FAIL cancel_nomatch: replay/valid got %b/%b want 0/1", replay_valid, exe_valid); end
    exe_ready = 1'b1; step();
    issue(6'd4, 6'd5, 1'b1, 5'd15); ld_spec_cancel = 1'b1; ld_spec_preg = 6'd4;
    step(); idle();
    checks++; if (replay_valid !== 1'b1 || replay_rob_tag !== 5'd15 || exe_valid !== 1'b0) begin errors++; $display("FAIL cancel_incoming: got %b/%0d/%b want 1/15/0", replay_valid, replay_rob_tag, exe_valid); end
    step();
  endtask

  task automatic test_flush;
    exe_ready = 1'b0;
    issue(6'd10, 6'd0, 1'b0, 5'd10); step();
    issue(6'd11, 6'd0, 1'b0, 5'd11); step();
    issue(6'd12, 6'd0, 1'b0, 5'd12); flush = 1'b1; ld_spec_cancel = 1'b1; ld_spec_preg = 6'd11;
    step(); idle();
    checks++; if (exe_valid !== 1'b0 || replay_valid !== 1'b0) begin errors++; $display("FAIL flush_outputs: valid/replay got %b/%b want 0/0", exe_valid, replay_valid); end
    checks++; if (rr_ready !== 1'b1 || rr_state !== RR_EMPTY) begin errors++; $display("FAIL flush_state: ready/state got %b/%0d want 1/0", rr_ready, rr_state); end
    step();
  endtask

  task automatic test_reset_mid;
    exe_ready = 1'b0;
    issue(6'd13, 6'd0, 1'b0, 5'd13); step();
    issue(6'd14, 6'd0, 1'b0, 5'd14); step();
    idle(); ld_spec_cancel = 1'b1; ld_spec_preg = 6'd14; rst = 1'b1;
    step(); idle();
    checks++; if (exe_valid !== 1'b0 || replay_valid !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: valid/replay got %b/%b want 0/0", exe_valid, replay_valid); end
    checks++; if (rr_ready !== 1'b1 || rr_state !== RR_EMPTY) begin errors++; $display("FAIL rstmid_state: ready/state got %b/%0d want 1/0", rr_ready, rr_state); end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prf[i] = 32'hF000_0000 | i;
    prf[5] = 32'h1000;
    prf[9] = 32'h9999;
    test_reset();
    test_single();
    test_bypass();
    test_back_to_back();
    test_cancel();
    test_cancel_edges();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
